simon_seq_game: RTL

Parametrised sequence-memory game controller. It stores a colour sequence of up to MAX_LEN entries, each COLOR_W bits wide. Game play runs in rounds of increasing length: the controller shows the first r entries, then checks r player inputs against them. It sits between the board's colour buttons/LEDs and the scoring logic, and generalises the single-guess Simon FSM to multi-colour, multi-round play.

---
 rtl/simon_seq_game.sv | 138 +++++++++++++
 1 files changed

// File: rtl/simon_seq_game.sv
// rtl/simon_seq_game.sv - multi-round sequence-memory game controller
module simon_seq_game #(
  parameter int COLOR_W = 2,
  parameter int MAX_LEN = 8,
  localparam int LEN_W = $clog2(MAX_LEN + 1),
  localparam int AW    = $clog2(MAX_LEN)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               seq_we,
  input  logic [AW-1:0]      seq_addr,
  input  logic [COLOR_W-1:0] seq_data,
  input  logic [LEN_W-1:0]   seq_len,
  input  logic               start,
  input  logic               in_valid,
  input  logic [COLOR_W-1:0] in,
  output logic               show_valid,
  output logic [COLOR_W-1:0] show_color,
  output logic               hit,
  output logic [1:0]         out,
  output logic [LEN_W-1:0]   level,
  output logic               busy
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SHOW = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_WIN  = 3'd3;
  localparam logic [2:0] ST_FAIL = 3'd4;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE_L     = LEN_W'(1);

  logic [2:0]         state_q, state_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [LEN_W-1:0]   r_q, r_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [1:0]         out_q, out_d;
  logic               hit_q, hit_d;
  logic [COLOR_W-1:0] mem_q [MAX_LEN];
  logic [COLOR_W-1:0] mem_d [MAX_LEN];

  logic               busy_w;
  logic               last_idx;
  logic               len_ok;
  logic [COLOR_W-1:0] cur_color;

  assign busy_w    = (state_q == ST_SHOW) || (state_q == ST_WAIT);
  assign last_idx  = (LEN_W'(idx_q) == (r_q - ONE_L));
  assign len_ok    = (seq_len != '0) && (seq_len <= MAX_LEN_L);
  assign cur_color = mem_q[idx_q];

  // Sequence memory: host writes land only while no game round is in progress.
  always_comb begin
    for (int i = 0; i < MAX_LEN; i++) mem_d[i] = mem_q[i];
    if (seq_we && !busy_w && (LEN_W'(seq_addr) < MAX_LEN_L)) begin
      mem_d[seq_addr] = seq_data;
    end
  end

  // Game FSM: show r entries, then check r player inputs, growing r each round.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    r_d     = r_q;
    len_d   = len_q;
    out_d   = out_q;
    hit_d   = 1'b0;
    case (state_q)
      ST_SHOW: begin
        if (last_idx) begin
          idx_d   = '0;
          state_d = ST_WAIT;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      ST_WAIT: begin
        if (in_valid) begin
          if (in == cur_color) begin
            hit_d = 1'b1;
            if (!last_idx) begin
              idx_d = idx_q + AW'(1);
            end else if (r_q != len_q) begin
              r_d     = r_q + ONE_L;
              idx_d   = '0;
              state_d = ST_SHOW;
            end else begin
              out_d   = 2'd2;
              state_d = ST_WIN;
            end
          end else begin
            out_d   = 2'd1;
            state_d = ST_FAIL;
          end
        end
      end
      default: begin
        if (start && len_ok) begin
          len_d   = seq_len;
          r_d     = ONE_L;
          idx_d   = '0;
          out_d   = 2'd0;
          state_d = ST_SHOW;
        end
      end
    endcase
  end

  // State and memory registers, all cleared by the asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      r_q     <= '0;
      len_q   <= '0;
      out_q   <= 2'd0;
      hit_q   <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      r_q     <= r_d;
      len_q   <= len_d;
      out_q   <= out_d;
      hit_q   <= hit_d;
      for (int i = 0; i < MAX_LEN; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign show_valid = (state_q == ST_SHOW);
  assign show_color = show_valid ? cur_color : '0;
  assign hit        = hit_q;
  assign out        = out_q;
  assign level      = r_q;
  assign busy       = busy_w;

endmodule
